// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory: default geometry, latency,
// counter width, FSM state encoding and saturating-increment helpers.
// Optional feature macro: DMEM_PERF_EN (performance counters in data_memory_block).
package dmem_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_ADDR_W  = 6;
  localparam int DMEM_LATENCY = 40;
  localparam int DMEM_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = v;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dmem_delay_counter.sv
// Down-counter that times one memory access: loaded when a request is
// accepted, decremented while the access is in flight, flags zero.
module dmem_delay_counter
  import dmem_pkg::*;
#(
  parameter int CNT_W = DMEM_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load has priority over decrement; decrement never wraps below zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/data_memory_block.sv
// Block-organised data memory answering cache refill / write-back requests.
// One request at a time; mem_busywait is held high for LATENCY cycles.
// Optional feature macro: DMEM_PERF_EN adds read/write/conflict counters.
module data_memory_block
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait
`ifdef DMEM_PERF_EN
  ,
  output logic [15:0]       read_count,
  output logic [15:0]       write_count,
  output logic [7:0]        conflict_count
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DMEM_CNT_W-1:0] LOAD_VAL = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_e       state_r;
  dmem_state_e       state_nxt_s;
  logic              op_rd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] readdata_r;
  logic              busy_r;
  logic              start_s;
  logic              finish_s;
  logic              conflict_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic [DMEM_CNT_W-1:0] cnt_s;

  // Next-state decode; simultaneous read and write in IDLE is a requester bug and is dropped
  always_comb begin
    start_s     = 1'b0;
    finish_s    = 1'b0;
    conflict_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_read ^ mem_write) begin
          start_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end else if (mem_read & mem_write) begin
          conflict_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_zero_s) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign cnt_dec_s = (state_r == ST_BUSY) && !cnt_zero_s;

  dmem_delay_counter #(
    .CNT_W(DMEM_CNT_W)
  ) u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       (start_s),
    .load_value (LOAD_VAL),
    .dec        (cnt_dec_s),
    .count      (cnt_s),
    .zero       (cnt_zero_s)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the request on acceptance so later input changes cannot disturb it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_rd_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (start_s) begin
      op_rd_r <= mem_read;
      addr_r  <= mem_address;
      wdata_r <= mem_writedata;
    end else begin
      op_rd_r <= op_rd_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Block storage; written only when a write access completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (finish_s && !op_rd_r) begin
      mem_r[addr_r] <= wdata_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

  // Registered responder outputs: busy for the whole access, read data held until next read ends
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r     <= 1'b0;
      readdata_r <= {DATA_W{1'b0}};
    end else begin
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      if (finish_s && op_rd_r) begin
        readdata_r <= mem_r[addr_r];
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  assign mem_busywait = busy_r;
  assign mem_readdata = readdata_r;

`ifdef DMEM_PERF_EN
  logic [15:0] read_count_r;
  logic [15:0] write_count_r;
  logic [7:0]  conflict_count_r;

  // Saturating activity counters: completed reads, completed writes, dropped conflicts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count_r     <= 16'd0;
      write_count_r    <= 16'd0;
      conflict_count_r <= 8'd0;
    end else begin
      if (finish_s && op_rd_r) begin
        read_count_r <= sat_inc16(read_count_r);
      end else begin
        read_count_r <= read_count_r;
      end
      if (finish_s && !op_rd_r) begin
        write_count_r <= sat_inc16(write_count_r);
      end else begin
        write_count_r <= write_count_r;
      end
      if (conflict_s) begin
        conflict_count_r <= sat_inc8(conflict_count_r);
      end else begin
        conflict_count_r <= conflict_count_r;
      end
    end
  end

  assign read_count     = read_count_r;
  assign write_count    = write_count_r;
  assign conflict_count = conflict_count_r;
`endif

endmodule
